// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state constants and burst helpers for axi_slave_mem.
// Defining AXI_SLAVE_MEM_WRAP_EN enables WRAP burst support.
package axi_pkg;

`ifdef AXI_SLAVE_MEM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef logic [1:0] w_state_t;
  localparam w_state_t W_IDLE = 2'd0;
  localparam w_state_t W_DATA = 2'd1;
  localparam w_state_t W_RESP = 2'd2;

  typedef logic r_state_t;
  localparam r_state_t R_IDLE = 1'b0;
  localparam r_state_t R_DATA = 1'b1;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address for FIXED, INCR and (when AXI_SLAVE_MEM_WRAP_EN is defined) WRAP bursts.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BYTES      = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            burst,
  input  logic [7:0]            len,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam int OFFS = $clog2(BYTES);

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    incr_addr = addr + ADDR_WIDTH'(BYTES);
    // Wrap boundary is the total burst size in bytes.
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << OFFS) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP: begin
        if (WRAP_EN) next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        else         next_addr = addr;
      end
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a word memory; independent single-outstanding write and read FSMs.
// WRAP bursts are supported only when AXI_SLAVE_MEM_WRAP_EN is defined.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 7,
  parameter int USER_WIDTH = 5,
  parameter int DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [USER_WIDTH-1:0]   s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [USER_WIDTH-1:0]   s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [USER_WIDTH-1:0]   s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [USER_WIDTH-1:0]   s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [USER_WIDTH-1:0]   s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int          BYTES      = DATA_WIDTH / 8;
  localparam int          OFFS       = $clog2(BYTES);
  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'(BYTES);
  localparam logic [2:0]  SIZE_FULL  = 3'(OFFS);

  // Decode error outranks every protocol error.
  function automatic logic [1:0] burst_resp(input logic [ADDR_WIDTH-1:0] addr,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input logic [7:0] len);
    if (64'(addr) >= ADDR_LIMIT) return RESP_DECERR;
    if (size != SIZE_FULL || burst == BURST_RSVD) return RESP_SLVERR;
    if (burst == BURST_WRAP && !(WRAP_EN && wrap_len_ok(len))) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awuser,
                           s_axi_wuser, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                           s_axi_aruser};

  // ---------------- write path ----------------
  w_state_t              w_state_q;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_next_addr;
  logic [7:0]            w_len_q, w_cnt_q;
  logic [1:0]            w_burst_q;
  logic [ID_WIDTH-1:0]   b_id_q;
  logic [1:0]            b_resp_q;
  logic                  w_last_beat, mem_we;

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYTES      (BYTES)
  ) u_w_addr (
    .addr      (w_addr_q),
    .burst     (w_burst_q),
    .len       (w_len_q),
    .next_addr (w_next_addr)
  );

  assign w_last_beat = (w_cnt_q == w_len_q);
  // The beat that exposes a wlast mismatch is still written; later beats are not.
  assign mem_we      = !rst && (w_state_q == W_DATA) && s_axi_wvalid && (b_resp_q == RESP_OKAY);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      b_id_q    <= '0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (s_axi_awvalid) begin
            w_addr_q  <= s_axi_awaddr;
            w_len_q   <= s_axi_awlen;
            w_burst_q <= s_axi_awburst;
            w_cnt_q   <= '0;
            b_id_q    <= s_axi_awid;
            b_resp_q  <= burst_resp(s_axi_awaddr, s_axi_awsize, s_axi_awburst, s_axi_awlen);
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid) begin
            w_addr_q <= w_next_addr;
            w_cnt_q  <= w_cnt_q + 8'd1;
            if ((s_axi_wlast != w_last_beat) && (b_resp_q == RESP_OKAY)) b_resp_q <= RESP_SLVERR;
            if (w_last_beat) w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi_wstrb[b]) mem[w_addr_q[OFFS +: IDX_W]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi_awready = (w_state_q == W_IDLE);
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bid     = b_id_q;
  assign s_axi_bresp   = b_resp_q;
  assign s_axi_buser   = '0;

  // ---------------- read path ----------------
  r_state_t              r_state_q;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_next_addr;
  logic [7:0]            r_len_q, r_cnt_q;
  logic [1:0]            r_burst_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [1:0]            r_resp_q, ar_resp;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic                  r_last_beat;

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYTES      (BYTES)
  ) u_r_addr (
    .addr      (r_addr_q),
    .burst     (r_burst_q),
    .len       (r_len_q),
    .next_addr (r_next_addr)
  );

  assign ar_resp     = burst_resp(s_axi_araddr, s_axi_arsize, s_axi_arburst, s_axi_arlen);
  assign r_last_beat = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);

  // Fetches use the pre-edge memory image, so a same-cycle write returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      r_id_q    <= '0;
      r_resp_q  <= RESP_OKAY;
      r_data_q  <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            r_addr_q  <= s_axi_araddr;
            r_len_q   <= s_axi_arlen;
            r_burst_q <= s_axi_arburst;
            r_cnt_q   <= '0;
            r_id_q    <= s_axi_arid;
            r_resp_q  <= ar_resp;
            r_data_q  <= (ar_resp == RESP_OKAY) ? mem[s_axi_araddr[OFFS +: IDX_W]] : '0;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (r_last_beat) begin
              r_state_q <= R_IDLE;
            end else begin
              r_addr_q <= r_next_addr;
              r_cnt_q  <= r_cnt_q + 8'd1;
              r_data_q <= (r_resp_q == RESP_OKAY) ? mem[r_next_addr[OFFS +: IDX_W]] : '0;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rid     = r_id_q;
  assign s_axi_rdata   = r_data_q;
  assign s_axi_rresp   = r_resp_q;
  assign s_axi_rlast   = r_last_beat;
  assign s_axi_ruser   = '0;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: stimulus pushes expected B/R responses, a monitor pops them.
module tb_axi_slave_mem;

  localparam logic [1:0] FIX = 2'b00, INC = 2'b01, WRP = 2'b10, RSV = 2'b11;
  localparam logic [1:0] OK = 2'b00, SLV = 2'b10, DEC = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock, awvalid, arvalid, awready, arready;
  logic [3:0]  awcache, arcache, awqos, arqos, wstrb;
  logic [4:0]  awuser, aruser, wuser, buser, ruser;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;
  bit rready_toggle = 1'b0;

  typedef struct packed {logic [6:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {logic [6:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;
  b_exp_t b_q[$];
  r_exp_t r_q[$];

  always #5 clk = ~clk;

  axi_slave_mem dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awid    (awid),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awsize  (awsize),
    .s_axi_awburst (awburst),
    .s_axi_awlock  (awlock),
    .s_axi_awcache (awcache),
    .s_axi_awprot  (awprot),
    .s_axi_awqos   (awqos),
    .s_axi_awuser  (awuser),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wuser   (wuser),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_buser   (buser),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arburst (arburst),
    .s_axi_arlock  (arlock),
    .s_axi_arcache (arcache),
    .s_axi_arprot  (arprot),
    .s_axi_arqos   (arqos),
    .s_axi_aruser  (aruser),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rid     (rid),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_ruser   (ruser),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_b(input logic [6:0] id, input logic [1:0] resp);
    b_q.push_back('{id: id, resp: resp});
  endtask

  task automatic push_r(input logic [6:0] id, input logic [31:0] d, input logic [1:0] resp,
                        input logic last);
    r_q.push_back('{id: id, data: d, resp: resp, last: last});
  endtask

  // Monitor: handshakes are seen at the negedge before the edge that completes them.
  initial begin
    b_exp_t be;
    r_exp_t re;
    logic [34:0] r_hold = '0;
    bit r_stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bvalid && bready) begin
        checks++;
        if (b_q.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected: got id %h resp %h expected no response", bid, bresp);
        end else begin
          checks--;
          be = b_q.pop_front();
          chk("b_resp", {bid, bresp, buser}, {be.id, be.resp, 5'd0});
        end
      end
      if (!rst && r_stalled && rvalid) chk("r_stable", {rdata, rresp, rlast}, r_hold);
      if (!rst && rvalid && rready) begin
        checks++;
        if (r_q.size() == 0) begin
          errors++;
          $display("FAIL r_unexpected: got data %h resp %h expected no beat", rdata, rresp);
        end else begin
          checks--;
          re = r_q.pop_front();
          chk("r_beat", {rid, rdata, rresp, rlast, ruser}, {re.id, re.data, re.resp, re.last, 5'd0});
        end
      end
      r_stalled = !rst && rvalid && !rready;
      r_hold    = {rdata, rresp, rlast};
    end
  end

  initial begin
    rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rready = rready_toggle ? ~rready : 1'b1;
    end
  end

  task automatic aw_send(input logic [6:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (awready) break;
    end
    if (n == 200) chk("aw_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] strb, input logic last);
    int n;
    wdata = d; wstrb = strb; wlast = last; wvalid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (wready) break;
    end
    if (n == 200) chk("w_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [6:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (arready) break;
    end
    if (n == 200) chk("ar_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("r_first_latency", rvalid, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (b_q.size() == 0 && r_q.size() == 0) break;
    end
    if (n == 2000) chk("drain_timeout", 64'(b_q.size() + r_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic write_single(input logic [6:0] id, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] strb);
    push_b(id, OK);
    aw_send(id, a, 8'd0, 3'd2, INC);
    w_send(d, strb, 1'b1);
    drain();
  endtask

  task automatic read_single(input logic [6:0] id, input logic [31:0] a, input logic [31:0] d);
    push_r(id, d, OK, 1'b1);
    ar_send(id, a, 8'd0, 3'd2, INC);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid} = '0;
    {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid} = '0;
    {wdata, wstrb, wlast, wuser, wvalid} = '0;
    bready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {awready, arready, wready}, 3'b110);
    chk("rst_valid", {bvalid, rvalid, rlast}, 3'b000);
    chk("rst_resp", {bresp, rresp}, 4'h0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ids", {bid, rid}, 14'h0);
    @(posedge clk); #1;

    // Single word write/read
    write_single(7'd5, 32'h10, 32'hDEADBEEF, 4'hF);
    read_single(7'd6, 32'h10, 32'hDEADBEEF);

    // INCR burst of four, read back with a stalling master
    push_b(7'd1, OK);
    aw_send(7'd1, 32'h0, 8'd3, 3'd2, INC);
    for (int i = 1; i <= 4; i++) w_send(32'(i), 4'hF, i == 4);
    drain();
    rready_toggle = 1'b1;
    for (int i = 1; i <= 4; i++) push_r(7'd2, 32'(i), OK, i == 4);
    ar_send(7'd2, 32'h0, 8'd3, 3'd2, INC);
    drain();
    rready_toggle = 1'b0;

    // Partial strobe
    write_single(7'd3, 32'h20, 32'hFFFFFFFF, 4'hF);
    write_single(7'd3, 32'h20, 32'hAAAA5555, 4'h3);
    read_single(7'd4, 32'h20, 32'hFFFF5555);

    // Out-of-range read, narrow write, and decode-over-slave error priority
    push_r(7'd8, 32'h0, DEC, 1'b1);
    ar_send(7'd8, 32'h1000, 8'd0, 3'd2, INC);
    drain();
    push_b(7'd9, SLV);
    aw_send(7'd9, 32'h10, 8'd0, 3'd1, INC);
    w_send(32'h12345678, 4'hF, 1'b1);
    drain();
    read_single(7'd10, 32'h10, 32'hDEADBEEF);
    push_b(7'd11, DEC);
    aw_send(7'd11, 32'h1000, 8'd0, 3'd2, RSV);
    w_send(32'h0, 4'hF, 1'b1);
    drain();

    // WRAP read over words 0x0..0xC holding 1..4
`ifdef AXI_SLAVE_MEM_WRAP_EN
    push_r(7'd12, 32'd3, OK, 1'b0);
    push_r(7'd12, 32'd4, OK, 1'b0);
    push_r(7'd12, 32'd1, OK, 1'b0);
    push_r(7'd12, 32'd2, OK, 1'b1);
    ar_send(7'd12, 32'h8, 8'd3, 3'd2, WRP);
    drain();
`else
    for (int i = 0; i < 4; i++) push_r(7'd12, 32'h0, SLV, i == 3);
    ar_send(7'd12, 32'h8, 8'd3, 3'd2, WRP);
    drain();
    push_b(7'd13, SLV);
    aw_send(7'd13, 32'h0, 8'd1, 3'd2, WRP);
    w_send(32'h99, 4'hF, 1'b0);
    w_send(32'h98, 4'hF, 1'b1);
    drain();
    read_single(7'd14, 32'h0, 32'd1);
`endif

    // FIXED burst keeps hitting one word
    push_b(7'd15, OK);
    aw_send(7'd15, 32'h40, 8'd1, 3'd2, FIX);
    w_send(32'h11, 4'hF, 1'b0);
    w_send(32'h22, 4'hF, 1'b1);
    drain();
    push_r(7'd16, 32'h22, OK, 1'b0);
    push_r(7'd16, 32'h22, OK, 1'b1);
    ar_send(7'd16, 32'h40, 8'd1, 3'd2, FIX);
    drain();

    // Early wlast
    push_b(7'd17, SLV);
    aw_send(7'd17, 32'h50, 8'd1, 3'd2, INC);
    w_send(32'h5, 4'hF, 1'b1);
    w_send(32'h6, 4'hF, 1'b1);
    drain();

    // Same-cycle write and read of one word returns the old value
    write_single(7'd18, 32'h80, 32'h1111, 4'hF);
    push_b(7'd19, OK);
    push_r(7'd20, 32'h1111, OK, 1'b1);
    aw_send(7'd19, 32'h80, 8'd0, 3'd2, INC);
    fork
      w_send(32'h2222, 4'hF, 1'b1);
      ar_send(7'd20, 32'h80, 8'd0, 3'd2, INC);
    join
    drain();
    read_single(7'd21, 32'h80, 32'h2222);

    // Reset during beat 2 of an 8-beat write
    aw_send(7'd3, 32'h60, 8'd7, 3'd2, INC);
    w_send(32'hA0, 4'hF, 1'b0);
    w_send(32'hA1, 4'hF, 1'b0);
    wdata = 32'hA2; wvalid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_awready", awready, 1);
    chk("mid_rst_wready", wready, 0);
    @(posedge clk); #1;
    push_r(7'd22, 32'hA0, OK, 1'b0);
    push_r(7'd22, 32'hA1, OK, 1'b1);
    ar_send(7'd22, 32'h60, 8'd1, 3'd2, INC);
    drain();
    read_single(7'd23, 32'h10, 32'hDEADBEEF);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
